// File: rtl/skinny_inv_sbox8_isw1_pini_hs.sv
// Two-share masked inverse SKINNY-128 8-bit S-box: eight refreshed ISW
// (x NOR y) XOR z gadgets in four layers behind a valid/ready handshake.
module skinny_inv_sbox8_isw1_pini_hs #(
    parameter int LAYER_CYCLES  = 2,
    parameter bit CLEAR_ON_DONE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  si0,
    input  logic [7:0]  si1,
    input  logic [15:0] r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  bo0,
    output logic [7:0]  bo1
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [2:0] LAST = 3'(4 * LAYER_CYCLES - 1);

    state_t          r_state;
    logic [2:0]      r_cnt;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [7:0]      r_bo0;
    logic [7:0]      r_bo1;
    logic [7:0]      r_s0;
    logic [7:0]      r_s1;
    logic [15:0]     r_m;
    logic [7:0][1:0] r_p;
    logic [7:0][1:0] r_qr;
    logic [7:0][3:0] r_u;

    logic            w_idle;
    logic            w_busy;
    logic            w_acc;
    logic            w_clr;
    logic [7:0]      w_x0;
    logic [7:0]      w_x1;
    logic [15:0]     w_m;
    logic [7:0][1:0] w_a;
    logic [7:0][1:0] w_g;
    logic [7:0][1:0] w_p;
    logic [7:0][1:0] w_q;
    logic [7:0][1:0] w_z;
    logic [7:0][3:0] w_u;
    logic [3:0]      w_lref;
    logic [3:0]      w_lprd;
    logic [7:0]      w_ref;
    logic [7:0]      w_prd;
    logic [7:0]      w_y0;
    logic [7:0]      w_y1;

    assign w_idle = (r_state == S_IDLE);
    assign w_busy = (r_state == S_BUSY);
    assign w_acc  = w_idle & in_valid;
    assign w_clr  = CLEAR_ON_DONE & (r_state == S_DONE) & out_ready;

    // Layer 1 refreshes on the accept edge, straight from the ports.
    assign w_x0 = w_idle ? si0 : r_s0;
    assign w_x1 = w_idle ? si1 : r_s1;
    assign w_m  = w_idle ? r : r_m;

    always_comb begin
        w_a[0] = {w_x1[6], w_x0[6]};
        w_a[1] = {w_x1[5], w_x0[5]};
        w_a[2] = {w_x1[2], w_x0[2]};
        w_a[3] = {w_x1[7], w_x0[7]};
        w_a[4] = {w_x1[3], w_x0[3]};
        w_a[5] = {w_x1[1], w_x0[1]};
        w_a[6] = {w_x1[4], w_x0[4]};
        w_a[7] = {w_x1[0], w_x0[0]};
        for (int k = 0; k < 8; k++) begin
            w_g[k] = {r_u[k][1] ^ r_u[k][0], r_u[k][2] ^ r_u[k][3]};
        end
        // g0=y2 g1=y3 g2=y7 g3=y5 g4=y1 g5=y0 g6=y6 g7=y4
        w_p = {w_g[2], w_g[0], w_g[1], w_a[1],
               w_a[0], w_a[2], w_a[3], w_a[4]};
        w_q = {w_g[6], w_g[4], w_g[0], w_g[1],
               w_a[1], w_a[3], w_a[0], w_a[5]};
        w_z = {w_a[0], w_a[2], w_a[1], w_a[4],
               w_a[3], w_a[5], w_a[6], w_a[7]};
        for (int k = 0; k < 8; k++) begin
            w_u[k][3] = (r_p[k][1] & r_qr[k][1]) ^ w_z[k][1];
            w_u[k][2] = (~r_p[k][0] & r_qr[k][1]) ^ w_m[2*k+1];
            w_u[k][1] = (r_p[k][1] & r_qr[k][0]) ^ w_m[2*k+1];
            w_u[k][0] = (~r_p[k][0] & r_qr[k][0]) ^ w_z[k][0];
        end
        for (int l = 0; l < 4; l++) begin
            w_lref[l] = (l == 0) ? w_acc
                      : w_busy && (r_cnt == 3'(LAYER_CYCLES * l - 1));
            w_lprd[l] = w_busy && (r_cnt == 3'(LAYER_CYCLES * l));
        end
        w_ref = {w_lref[3], w_lref[2], {2{w_lref[1]}}, {4{w_lref[0]}}};
        w_prd = {w_lprd[3], w_lprd[2], {2{w_lprd[1]}}, {4{w_lprd[0]}}};
        w_y0 = {w_g[2][0], w_g[6][0], w_g[3][0], w_g[7][0],
                w_g[1][0], w_g[0][0], w_g[4][0], w_g[5][0]};
        w_y1 = {w_g[2][1], w_g[6][1], w_g[3][1], w_g[7][1],
                w_g[1][1], w_g[0][1], w_g[4][1], w_g[5][1]};
    end

    always_ff @(posedge clk) begin
        if (rst || w_clr) begin
            r_s0 <= '0;
            r_s1 <= '0;
            r_m  <= '0;
            r_p  <= '0;
            r_qr <= '0;
            r_u  <= '0;
        end else begin
            if (w_acc) begin
                r_s0 <= si0;
                r_s1 <= si1;
                r_m  <= r;
            end
            for (int k = 0; k < 8; k++) begin
                if (w_ref[k]) begin
                    r_p[k]  <= w_p[k];
                    r_qr[k] <= {w_q[k][1] ^ w_m[2*k],
                                ~w_q[k][0] ^ w_m[2*k]};
                end
                if (w_prd[k]) begin
                    r_u[k] <= w_u[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_bo0       <= '0;
            r_bo1       <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: if (in_valid) begin
                    r_state    <= S_BUSY;
                    r_cnt      <= '0;
                    r_in_ready <= 1'b0;
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == LAST) begin
                        r_bo0       <= w_y0;
                        r_bo1       <= w_y1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign bo0       = r_bo0;
    assign bo1       = r_bo1;

endmodule

// File: tb/tb_skinny_inv_sbox8_isw1_pini_hs.sv
// Directed bench for the masked inverse SKINNY S-box: function, latency,
// backpressure, input isolation while busy and mid-operation reset.
module tb_skinny_inv_sbox8_isw1_pini_hs;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  si0;
    logic [7:0]  si1;
    logic [15:0] r;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  bo0;
    logic [7:0]  bo1;

    int checks   = 0;
    int failures = 0;

    skinny_inv_sbox8_isw1_pini_hs #(
        .LAYER_CYCLES (2),
        .CLEAR_ON_DONE(1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .si0      (si0),
        .si1      (si1),
        .r        (r),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .bo0      (bo0),
        .bo1      (bo1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Unmasked reference of the inverse S-box equations.
    function automatic logic [7:0] inv_ref(input logic [7:0] x);
        logic a0, a1, a2, a3, a4, a5, a6, a7;
        logic y0, y1, y2, y3, y4, y5, y6, y7;
        a0 = x[6]; a1 = x[5]; a2 = x[2]; a3 = x[7];
        a4 = x[3]; a5 = x[1]; a6 = x[4]; a7 = x[0];
        y2 = ~(a4 | a5) ^ a7;
        y3 = ~(a3 | a0) ^ a6;
        y7 = ~(a2 | a3) ^ a5;
        y5 = ~(a0 | a1) ^ a3;
        y1 = ~(a1 | y3) ^ a4;
        y0 = ~(y3 | y2) ^ a1;
        y6 = ~(y2 | y1) ^ a2;
        y4 = ~(y7 | y6) ^ a0;
        return {y7, y6, y5, y4, y3, y2, y1, y0};
    endfunction

    task automatic start(input string tag, input logic [7:0] s0,
                         input logic [7:0] s1, input logic [15:0] rr);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk({tag, "_rdy_timeout"}, 32'(in_ready), 32'd1);
        si0      = s0;
        si1      = s1;
        r        = rr;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd8);
    endtask

    task automatic finish_op(input string tag, input logic [7:0] exp);
        logic [7:0] b0, b1;
        chk({tag, "_y"}, 32'(bo0 ^ bo1), 32'(exp));
        b0 = bo0;
        b1 = bo1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
        chk({tag, "_bo_kept"}, {16'd0, bo0, bo1}, {16'd0, b0, b1});
    endtask

    task automatic do_op(input string tag, input logic [7:0] s0,
                         input logic [7:0] s1, input logic [15:0] rr,
                         input logic [7:0] exp);
        start(tag, s0, s1, rr);
        wait_done(tag);
        finish_op(tag, exp);
    endtask

    initial begin
        logic [7:0] x, s, b0, b1;
        int n;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        si0       = '0;
        si1       = '0;
        r         = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_bo", {16'd0, bo0, bo1}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op("t1_65", 8'h65, 8'h00, 16'h0000, 8'h00);
        for (int i = 0; i < 40; i++) begin
            do_op("t2_5a3f", 8'h5A, 8'h3F, 16'($urandom), 8'h00);
        end
        s = 8'($urandom);
        do_op("t3_ff", s, s ^ 8'hFF, 16'($urandom), 8'hFF);
        s = 8'($urandom);
        do_op("t3_4c", s, s ^ 8'h4C, 16'($urandom), 8'h01);
        for (int i = 0; i < 256; i++) begin
            x = 8'(i);
            s = 8'($urandom);
            do_op("t3_all", s, s ^ x, 16'($urandom), inv_ref(x));
        end

        start("t4", 8'h12, 8'h34, 16'($urandom));
        wait_done("t4");
        b0       = bo0;
        b1       = bo1;
        si0      = 8'h4C;
        si1      = 8'h00;
        r        = 16'hA5C3;
        in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("t4_hold", {14'd0, out_valid, in_ready, bo0, bo1},
                {14'd0, 1'b1, 1'b0, b0, b1});
        end
        chk("t4_y", 32'(bo0 ^ bo1), 32'(inv_ref(8'h26)));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t4_no_same_cycle_acc", {30'd0, in_ready, out_valid}, 32'b10);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t4_late_acc", 32'(in_ready), 32'd0);
        wait_done("t4b");
        finish_op("t4b", 8'h01);

        x = 8'h9C;
        s = 8'($urandom);
        start("t5", s, s ^ x, 16'($urandom));
        n = 0;
        while (!out_valid && n < 20) begin
            si0      = 8'($urandom);
            si1      = 8'($urandom);
            r        = 16'($urandom);
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        chk("t5_lat", 32'(n), 32'd8);
        finish_op("t5", inv_ref(x));

        start("t6", 8'h5A, 8'h3F, 16'h1234);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst", {14'd0, out_valid, in_ready, bo0, bo1},
            {14'd0, 1'b0, 1'b1, 16'd0});
        rst = 1'b0;
        @(negedge clk);
        chk("t6_quiet", 32'(out_valid), 32'd0);
        do_op("t6_after", 8'h33, 8'h33 ^ 8'h4C, 16'hBEEF, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
